// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - GPR scoreboard for long-latency producers
//
// Purpose: tracks destination GPRs of issued long-latency producers (loads,
// mul/div) until writeback, and holds ID while an instruction in ID needs
// one of those registers.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_reg1_raddr_i/RE_i     ID source 1 address / read enable
//   id_reg2_raddr_i/RE_i     ID source 2 address / read enable
//   id_reg_waddr_i/we_i      ID destination address / write enable
//   id_long_i                ID instruction is a long-latency producer
//   id_issue_i               ID instruction leaves ID this cycle (pre-stall)
//   flush_i                  ID instruction killed this cycle
//   wb_reg_waddr_i           long-latency writeback destination
//   wb_long_we_i             long-latency result written this cycle
//   sb_stall_o               hold ID (combinational)
//   sb_busy_o                pending bitmap (registered)
//   sb_cnt_o                 number of pending entries (registered)
//   sb_err_o                 sticky protocol error (registered)

module reg_scoreboard #(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int MAX_OUT = 4,
  parameter int CW      = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   id_reg1_raddr_i,
  input  logic [AW-1:0]   id_reg2_raddr_i,
  input  logic            id_reg1_RE_i,
  input  logic            id_reg2_RE_i,
  input  logic [AW-1:0]   id_reg_waddr_i,
  input  logic            id_reg_we_i,
  input  logic            id_long_i,
  input  logic            id_issue_i,
  input  logic            flush_i,
  input  logic [AW-1:0]   wb_reg_waddr_i,
  input  logic            wb_long_we_i,
  output logic            sb_stall_o,
  output logic [NREG-1:0] sb_busy_o,
  output logic [CW-1:0]   sb_cnt_o,
  output logic            sb_err_o
);

  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            raw_hit1, raw_hit2, waw_hit, full_hit;
  logic            set, clr, spurious_wb, overflow_set;
  logic [CW-1:0]   cnt_after_clr;

  // Hazard detection. A register being written back this very cycle is
  // never a hazard: its value comes from the WB forwarding path.
  always_comb begin
    raw_hit1 = id_reg1_RE_i && (id_reg1_raddr_i != '0) && busy_q[id_reg1_raddr_i]
               && !(wb_long_we_i && (wb_reg_waddr_i == id_reg1_raddr_i));
    raw_hit2 = id_reg2_RE_i && (id_reg2_raddr_i != '0) && busy_q[id_reg2_raddr_i]
               && !(wb_long_we_i && (wb_reg_waddr_i == id_reg2_raddr_i));
    // Any second writer to a pending register waits, so each bit tracks at
    // most one outstanding producer.
    waw_hit  = id_reg_we_i && (id_reg_waddr_i != '0) && busy_q[id_reg_waddr_i]
               && !(wb_long_we_i && (wb_reg_waddr_i == id_reg_waddr_i));

    clr           = wb_long_we_i && (wb_reg_waddr_i != '0) && busy_q[wb_reg_waddr_i];
    spurious_wb   = wb_long_we_i && (wb_reg_waddr_i != '0) && !busy_q[wb_reg_waddr_i];
    // A retiring entry frees its slot in the same cycle.
    cnt_after_clr = clr ? (cnt_q - ONE_C) : cnt_q;
    full_hit      = id_long_i && id_reg_we_i && (id_reg_waddr_i != '0)
                    && (cnt_after_clr == MAX_OUT_C);

    sb_stall_o    = raw_hit1 || raw_hit2 || waw_hit || full_hit;

    set           = id_issue_i && !sb_stall_o && !flush_i && id_long_i
                    && id_reg_we_i && (id_reg_waddr_i != '0);
    // Unreachable while full_hit gates set; kept as a guard against a
    // broken stall path.
    overflow_set  = set && (cnt_q == MAX_OUT_C) && !clr;
  end

  // Next-state. Clear is applied before set so a same-index collision
  // leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    err_d  = err_q;

    if (clr) begin
      busy_d[wb_reg_waddr_i] = 1'b0;
    end
    if (set) begin
      busy_d[id_reg_waddr_i] = 1'b1;
    end

    if (set && !clr) begin
      cnt_d = cnt_q + ONE_C;
    end else if (clr && !set) begin
      cnt_d = cnt_q - ONE_C;
    end

    if (spurious_wb || overflow_set) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign sb_busy_o = busy_q;
  assign sb_cnt_o  = cnt_q;
  assign sb_err_o  = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - self-checking bench for reg_scoreboard
module tb_reg_scoreboard;

  localparam int NREG    = 32;
  localparam int AW      = 5;
  localparam int MAX_OUT = 4;
  localparam int CW      = 6;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   id_reg1_raddr_i, id_reg2_raddr_i, id_reg_waddr_i, wb_reg_waddr_i;
  logic            id_reg1_RE_i, id_reg2_RE_i, id_reg_we_i, id_long_i;
  logic            id_issue_i, flush_i, wb_long_we_i;
  logic            sb_stall_o;
  logic [NREG-1:0] sb_busy_o;
  logic [CW-1:0]   sb_cnt_o;
  logic            sb_err_o;

  reg_scoreboard #(.NREG(NREG), .AW(AW), .MAX_OUT(MAX_OUT), .CW(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_reg1_raddr_i (id_reg1_raddr_i),
    .id_reg2_raddr_i (id_reg2_raddr_i),
    .id_reg1_RE_i    (id_reg1_RE_i),
    .id_reg2_RE_i    (id_reg2_RE_i),
    .id_reg_waddr_i  (id_reg_waddr_i),
    .id_reg_we_i     (id_reg_we_i),
    .id_long_i       (id_long_i),
    .id_issue_i      (id_issue_i),
    .flush_i         (flush_i),
    .wb_reg_waddr_i  (wb_reg_waddr_i),
    .wb_long_we_i    (wb_long_we_i),
    .sb_stall_o      (sb_stall_o),
    .sb_busy_o       (sb_busy_o),
    .sb_cnt_o        (sb_cnt_o),
    .sb_err_o        (sb_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         rst;
    logic [4:0]   r1;
    logic         re1;
    logic [4:0]   r2;
    logic         re2;
    logic [4:0]   wa;
    logic         we;
    logic         lng;
    logic         iss;
    logic         fl;
    logic [4:0]   wba;
    logic         wbwe;
    int           exp_stall;   // -1: not checked
    logic [31:0]  exp_busy;
    int           exp_cnt;
    logic         exp_err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] m_busy;
  int          m_cnt;
  logic        m_err;

  function automatic vec_t mk(string n, bit r, int r1, bit re1, int r2, bit re2,
                              int wa, bit we, bit lng, bit iss, bit fl,
                              int wba, bit wbwe,
                              int st, logic [31:0] eb, int ec, bit ee);
    vec_t v;
    v.name = n; v.rst = r;
    v.r1 = 5'(r1); v.re1 = re1; v.r2 = 5'(r2); v.re2 = re2;
    v.wa = 5'(wa); v.we = we; v.lng = lng; v.iss = iss; v.fl = fl;
    v.wba = 5'(wba); v.wbwe = wbwe;
    v.exp_stall = st; v.exp_busy = eb; v.exp_cnt = ec; v.exp_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.rst;
    id_reg1_raddr_i = v.r1; id_reg1_RE_i = v.re1;
    id_reg2_raddr_i = v.r2; id_reg2_RE_i = v.re2;
    id_reg_waddr_i = v.wa; id_reg_we_i = v.we; id_long_i = v.lng;
    id_issue_i = v.iss; flush_i = v.fl;
    wb_reg_waddr_i = v.wba; wb_long_we_i = v.wbwe;
    sb_q.push_back(v);
    #1;
    if (v.exp_stall >= 0) check({v.name, ".stall"}, 32'(sb_stall_o), 32'(v.exp_stall));
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({e.name, ".busy"}, sb_busy_o, e.exp_busy);
    check({e.name, ".cnt"}, 32'(sb_cnt_o), 32'(e.exp_cnt));
    check({e.name, ".err"}, 32'(sb_err_o), 32'(e.exp_err));
  endtask

  // Behavioural reference: fills in the expected fields of v from the
  // current model state and advances the model.
  task automatic model_step(inout vec_t v);
    bit raw1, raw2, waw, clr, full, stall, set, spur;
    logic [31:0] nb;
    int nc;
    raw1  = v.re1 && v.r1 != 0 && m_busy[v.r1] && !(v.wbwe && v.wba == v.r1);
    raw2  = v.re2 && v.r2 != 0 && m_busy[v.r2] && !(v.wbwe && v.wba == v.r2);
    waw   = v.we && v.wa != 0 && m_busy[v.wa] && !(v.wbwe && v.wba == v.wa);
    clr   = v.wbwe && v.wba != 0 && m_busy[v.wba];
    spur  = v.wbwe && v.wba != 0 && !m_busy[v.wba];
    full  = v.lng && v.we && v.wa != 0 && (m_cnt - int'(clr)) == MAX_OUT;
    stall = raw1 || raw2 || waw || full;
    set   = v.iss && !stall && !v.fl && v.lng && v.we && v.wa != 0;
    nb = m_busy;
    if (clr) nb[v.wba] = 1'b0;
    if (set) nb[v.wa] = 1'b1;
    nc = m_cnt + int'(set) - int'(clr);
    v.exp_stall = int'(stall);
    if (v.rst) begin
      m_busy = '0; m_cnt = 0; m_err = 1'b0;
    end else begin
      m_err  = m_err || spur || (set && m_cnt == MAX_OUT && !clr);
      m_busy = nb; m_cnt = nc;
    end
    v.exp_busy = m_busy; v.exp_cnt = m_cnt; v.exp_err = m_err;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst = 1'b1;
    id_reg1_raddr_i = '0; id_reg2_raddr_i = '0; id_reg_waddr_i = '0; wb_reg_waddr_i = '0;
    id_reg1_RE_i = 0; id_reg2_RE_i = 0; id_reg_we_i = 0; id_long_i = 0;
    id_issue_i = 0; flush_i = 0; wb_long_we_i = 0;

    //                 name                    rst r1 re1 r2 re2 wa we lg is fl wba wbwe  st  busy        cnt err
    tbl.push_back(mk("reset",                 1,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0,   -1, 32'h0,      0, 0));
    tbl.push_back(mk("lu_issue_x5",           0,  0, 0, 0, 0,   5, 1, 1, 1, 0, 0, 0,    0, 32'h20,     1, 0));
    tbl.push_back(mk("lu_read_x5",            0,  5, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0,    1, 32'h20,     1, 0));
    tbl.push_back(mk("lu_hold_x5",            0,  5, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0,    1, 32'h20,     1, 0));
    tbl.push_back(mk("lu_wb_x5",              0,  5, 1, 0, 0,   0, 0, 0, 0, 0, 5, 1,    0, 32'h0,      0, 0));
    tbl.push_back(mk("sc_issue_x7",           0,  0, 0, 0, 0,   7, 1, 1, 1, 0, 0, 0,    0, 32'h80,     1, 0));
    tbl.push_back(mk("sc_rd2_wb_x7",          0,  0, 0, 7, 1,   0, 0, 0, 0, 0, 7, 1,    0, 32'h0,      0, 0));
    tbl.push_back(mk("short_write_x7",        0,  0, 0, 0, 0,   7, 1, 0, 1, 0, 0, 0,    0, 32'h0,      0, 0));
    tbl.push_back(mk("waw_issue_x3",          0,  0, 0, 0, 0,   3, 1, 1, 1, 0, 0, 0,    0, 32'h8,      1, 0));
    tbl.push_back(mk("waw_long_x3",           0,  0, 0, 0, 0,   3, 1, 1, 1, 0, 0, 0,    1, 32'h8,      1, 0));
    tbl.push_back(mk("waw_short_x3",          0,  0, 0, 0, 0,   3, 1, 0, 0, 0, 0, 0,    1, 32'h8,      1, 0));
    tbl.push_back(mk("x0_long_write",         0,  0, 0, 0, 0,   0, 1, 1, 1, 0, 0, 0,    0, 32'h8,      1, 0));
    tbl.push_back(mk("x0_read",               0,  0, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0,    0, 32'h8,      1, 0));
    tbl.push_back(mk("waw_same_cycle_wb_x3",  0,  0, 0, 0, 0,   3, 1, 1, 1, 0, 3, 1,    0, 32'h8,      1, 0));
    tbl.push_back(mk("wb_x3",                 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 3, 1,    0, 32'h0,      0, 0));
    tbl.push_back(mk("cap_x1",                0,  0, 0, 0, 0,   1, 1, 1, 1, 0, 0, 0,    0, 32'h2,      1, 0));
    tbl.push_back(mk("cap_x2",                0,  0, 0, 0, 0,   2, 1, 1, 1, 0, 0, 0,    0, 32'h6,      2, 0));
    tbl.push_back(mk("cap_x3",                0,  0, 0, 0, 0,   3, 1, 1, 1, 0, 0, 0,    0, 32'he,      3, 0));
    tbl.push_back(mk("cap_x4",                0,  0, 0, 0, 0,   4, 1, 1, 1, 0, 0, 0,    0, 32'h1e,     4, 0));
    tbl.push_back(mk("cap_full_x9",           0,  0, 0, 0, 0,   9, 1, 1, 1, 0, 0, 0,    1, 32'h1e,     4, 0));
    tbl.push_back(mk("cap_full_short_x9",     0,  0, 0, 0, 0,   9, 1, 0, 1, 0, 0, 0,    0, 32'h1e,     4, 0));
    tbl.push_back(mk("cap_wb_x1_x9",          0,  0, 0, 0, 0,   9, 1, 1, 1, 0, 1, 1,    0, 32'h21c,    4, 0));
    tbl.push_back(mk("raw_rs1_x2",            0,  2, 1, 10, 1,  0, 0, 0, 0, 0, 0, 0,    1, 32'h21c,    4, 0));
    tbl.push_back(mk("raw_rs2_x4",            0,  0, 0, 4, 1,   0, 0, 0, 0, 0, 0, 0,    1, 32'h21c,    4, 0));
    tbl.push_back(mk("no_re_x4",              0,  4, 0, 9, 0,   0, 0, 0, 0, 0, 0, 0,    0, 32'h21c,    4, 0));
    tbl.push_back(mk("drain_x2",              0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 2, 1,    0, 32'h218,    3, 0));
    tbl.push_back(mk("drain_x3",              0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 3, 1,    0, 32'h210,    2, 0));
    tbl.push_back(mk("drain_x4",              0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 4, 1,    0, 32'h200,    1, 0));
    tbl.push_back(mk("drain_x9",              0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 9, 1,    0, 32'h0,      0, 0));
    tbl.push_back(mk("wb_x0",                 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1,    0, 32'h0,      0, 0));
    tbl.push_back(mk("flush_x6",              0,  0, 0, 0, 0,   6, 1, 1, 1, 1, 0, 0,    0, 32'h0,      0, 0));
    tbl.push_back(mk("spurious_wb_x6",        0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 6, 1,    0, 32'h0,      0, 1));
    tbl.push_back(mk("err_sticky",            0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0,    0, 32'h0,      0, 1));
    tbl.push_back(mk("reset_err",             1,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0,    0, 32'h0,      0, 0));
    tbl.push_back(mk("mo_issue_x2",           0,  0, 0, 0, 0,   2, 1, 1, 1, 0, 0, 0,    0, 32'h4,      1, 0));
    tbl.push_back(mk("mo_issue_x8",           0,  0, 0, 0, 0,   8, 1, 1, 1, 0, 0, 0,    0, 32'h104,    2, 0));
    tbl.push_back(mk("mo_rst",                1,  0, 0, 0, 0,  10, 1, 1, 1, 0, 2, 1,    0, 32'h0,      0, 0));
    tbl.push_back(mk("mo_read_after",         0,  2, 1, 8, 1,   0, 0, 0, 0, 0, 0, 0,    0, 32'h0,      0, 0));
    tbl.push_back(mk("mo_late_wb_x2",         0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 2, 1,    0, 32'h0,      0, 1));
    tbl.push_back(mk("final_rst",             1,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0,    0, 32'h0,      0, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Randomised traffic on a small register window against the model.
    m_busy = '0; m_cnt = 0; m_err = 1'b0;
    for (int n = 0; n < 400; n++) begin
      v = mk($sformatf("rnd%0d", n), ($urandom_range(0, 59) == 0),
             $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 7), ($urandom_range(0, 3) != 0),
             $urandom_range(0, 1), $urandom_range(0, 1),
             ($urandom_range(0, 9) == 0),
             $urandom_range(0, 7), ($urandom_range(0, 2) == 0),
             0, 32'h0, 0, 0);
      // Steer most writebacks onto a pending register to keep err meaningful.
      if (v.wbwe && !m_busy[v.wba] && $urandom_range(0, 9) != 0) begin
        for (int k = 1; k < 8; k++) begin
          if (m_busy[k]) v.wba = 5'(k);
        end
      end
      model_step(v);
      apply(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
